// File: rtl/sd_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_mem_arb_pkg
// Description : Shared types and constants for the two-master on-chip RAM
//               arbiter (Nios II data master vs. SD block-transfer DMA).
// Revision    : 1.0 - initial release
// ============================================================================
package sd_mem_arb_pkg;

  localparam int ADDR_W     = 14;  // 16384 words
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int HOLD_CNT_W = 4;

  // Saturation value of the consecutive-grant counter
  localparam logic [HOLD_CNT_W-1:0] HOLD_CNT_MAX = '1;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DMA = 1'b1
  } master_id_t;

  // The master that is not `id`
  function automatic master_id_t other_master(input master_id_t id);
    return (id == M_CPU) ? M_DMA : M_CPU;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : sd_mem_arb_rr
// Description : Pure combinational grant / fairness logic. Weighted
//               round-robin with a bounded hold count: the current owner may
//               keep the RAM for at most MAX_HOLD consecutive grants while the
//               other master waits. MAX_HOLD must lie in 1..15.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_mem_arb_rr
  import sd_mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic [1:0]            req,
  input  logic                  owner_valid,
  input  master_id_t            last_owner,
  input  logic [HOLD_CNT_W-1:0] hold_cnt,
  output logic [1:0]            grant,
  output logic                  grant_valid,
  output master_id_t            grant_id,
  output master_id_t            next_last_owner,
  output logic [HOLD_CNT_W-1:0] next_hold_cnt
);

  // Owner keeps the RAM while hold_cnt is below this value
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD - 1);

  // Pick the grantee. Until any grant has happened since reset there is no
  // real owner, so contention goes to the master other than last_owner; this
  // is what lets the reset value last_owner=DMA hand the first contention to
  // the CPU.
  always_comb begin
    grant_valid = |req;
    grant_id    = M_CPU;
    if (req == 2'b10) begin
      grant_id = M_DMA;
    end else if (req == 2'b11) begin
      if (owner_valid && (hold_cnt < HOLD_LIMIT)) begin
        grant_id = last_owner;
      end else begin
        grant_id = other_master(last_owner);
      end
    end
    grant = 2'b00;
    if (grant_valid) begin
      grant = (grant_id == M_DMA) ? 2'b10 : 2'b01;
    end
  end

  // Fairness state update: count repeat grants, restart on an owner change
  always_comb begin
    next_last_owner = last_owner;
    next_hold_cnt   = hold_cnt;
    if (grant_valid) begin
      if (owner_valid && (grant_id == last_owner)) begin
        if (hold_cnt != HOLD_CNT_MAX) begin
          next_hold_cnt = hold_cnt + HOLD_CNT_W'(1);
        end
      end else begin
        next_last_owner = grant_id;
        next_hold_cnt   = '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_nios2_attempt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sd_nios2_attempt_mem_arbiter
// Description : Two-master Avalon-MM arbiter in front of the 16K x 32
//               single-port on-chip RAM. One access per cycle, zero-wait
//               issue, fixed 1-cycle read latency tracked so each read's data
//               returns to its issuer with readdatavalid.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_nios2_attempt_mem_arbiter #(
  parameter int ADDR_W   = sd_mem_arb_pkg::ADDR_W,
  parameter int DATA_W   = sd_mem_arb_pkg::DATA_W,
  parameter int BE_W     = sd_mem_arb_pkg::BE_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  // master 0 : Nios II data master
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_waitrequest,
  // master 1 : SD block-transfer DMA
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_waitrequest,
  // on-chip RAM
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  import sd_mem_arb_pkg::*;

  // Fairness state
  master_id_t            r_last_owner;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic                  r_owner_valid;

  // Read-return pipeline and per-master held read data
  logic                  r_rd_pend;
  master_id_t            r_rd_id;
  logic [DATA_W-1:0]     r_m0_rd_hold;
  logic [DATA_W-1:0]     r_m1_rd_hold;

  logic [1:0]            w_req;
  logic [1:0]            w_grant_raw;
  logic                  w_grant_valid_raw;
  logic [1:0]            w_grant;
  logic                  w_grant_valid;
  master_id_t            w_grant_id;
  master_id_t            w_next_owner;
  logic [HOLD_CNT_W-1:0] w_next_hold;
  logic                  w_grant_write;
  logic                  w_rd_ret;

  // A simultaneous read+write is a protocol violation; it still counts as one
  // request and is later executed as a write.
  assign w_req = {m1_read | m1_write, m0_read | m0_write};

  sd_mem_arb_rr #(
    .MAX_HOLD (MAX_HOLD)
  ) u_rr (
    .req             (w_req),
    .owner_valid     (r_owner_valid),
    .last_owner      (r_last_owner),
    .hold_cnt        (r_hold_cnt),
    .grant           (w_grant_raw),
    .grant_valid     (w_grant_valid_raw),
    .grant_id        (w_grant_id),
    .next_last_owner (w_next_owner),
    .next_hold_cnt   (w_next_hold)
  );

  // Nothing is granted while reset is held
  assign w_grant       = reset ? 2'b00 : w_grant_raw;
  assign w_grant_valid = w_grant_valid_raw & ~reset;
  assign w_grant_write = (w_grant_id == M_DMA) ? m1_write : m0_write;

  // RAM drive muxed from the grantee
  always_comb begin
    mem_address    = (w_grant_id == M_DMA) ? m1_address    : m0_address;
    mem_byteenable = (w_grant_id == M_DMA) ? m1_byteenable : m0_byteenable;
    mem_writedata  = (w_grant_id == M_DMA) ? m1_writedata  : m0_writedata;
    mem_chipselect = w_grant_valid;
    mem_write      = w_grant_valid & w_grant_write;
    mem_clken      = 1'b1;
  end

  // Stall every requester that did not win; all masters stall during reset
  always_comb begin
    m0_waitrequest = reset | (w_req[0] & ~w_grant[0]);
    m1_waitrequest = reset | (w_req[1] & ~w_grant[1]);
  end

  // Fairness state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_owner  <= M_DMA;
      r_hold_cnt    <= '0;
      r_owner_valid <= 1'b0;
    end else if (w_grant_valid) begin
      r_last_owner  <= w_next_owner;
      r_hold_cnt    <= w_next_hold;
      r_owner_valid <= 1'b1;
    end
  end

  // Track a granted read for one cycle to match the RAM latency
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend <= 1'b0;
      r_rd_id   <= M_CPU;
    end else begin
      r_rd_pend <= w_grant_valid & ~w_grant_write;
      if (w_grant_valid) begin
        r_rd_id <= w_grant_id;
      end
    end
  end

  // A pending read is discarded if reset arrives in its return cycle
  assign w_rd_ret = r_rd_pend & ~reset;

  // Route returning data; the other master's readdata keeps its last value
  always_comb begin
    m0_readdatavalid = w_rd_ret & (r_rd_id == M_CPU);
    m1_readdatavalid = w_rd_ret & (r_rd_id == M_DMA);
    m0_readdata      = m0_readdatavalid ? mem_readdata : r_m0_rd_hold;
    m1_readdata      = m1_readdatavalid ? mem_readdata : r_m1_rd_hold;
  end

  // Capture returned data so it stays visible to the issuer afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m0_rd_hold <= '0;
      r_m1_rd_hold <= '0;
    end else begin
      if (m0_readdatavalid) begin
        r_m0_rd_hold <= mem_readdata;
      end
      if (m1_readdatavalid) begin
        r_m1_rd_hold <= mem_readdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_nios2_attempt_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_nios2_attempt_mem_arbiter
// Description : Directed self-checking bench for the two-master RAM arbiter.
//               dut uses MAX_HOLD=4 with a behavioural 16K x 32 RAM; dut_alt
//               uses MAX_HOLD=1 with a read-only pattern RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_nios2_attempt_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [13:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;

  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  logic [31:0] a_m0_readdata, a_m1_readdata;
  logic        a_m0_readdatavalid, a_m1_readdatavalid, a_m0_waitrequest, a_m1_waitrequest;
  logic [13:0] a_mem_address;
  logic [3:0]  a_mem_byteenable;
  logic        a_mem_chipselect, a_mem_write, a_mem_clken;
  logic [31:0] a_mem_writedata, a_mem_readdata;

  int n_checks = 0;
  int n_fail   = 0;

  sd_nios2_attempt_mem_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid), .m1_waitrequest(m1_waitrequest),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  sd_nios2_attempt_mem_arbiter #(.MAX_HOLD(1)) dut_alt (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(a_m0_readdata),
    .m0_readdatavalid(a_m0_readdatavalid), .m0_waitrequest(a_m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(a_m1_readdata),
    .m1_readdatavalid(a_m1_readdatavalid), .m1_waitrequest(a_m1_waitrequest),
    .mem_address(a_mem_address), .mem_byteenable(a_mem_byteenable),
    .mem_chipselect(a_mem_chipselect), .mem_write(a_mem_write),
    .mem_writedata(a_mem_writedata), .mem_clken(a_mem_clken), .mem_readdata(a_mem_readdata)
  );

  // Preloaded RAM contents: each word holds a tag plus its own address
  function automatic logic [31:0] pat(input logic [13:0] a);
    return 32'hC0DE_0000 | {18'd0, a};
  endfunction

  // Behavioural RAM for dut: byte-lane writes, registered 1-cycle read
  logic [31:0] ram [0:16383];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16384; i++) ram[i] <= pat(14'(i));
    end else if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Read-only pattern RAM for dut_alt
  always @(posedge clk) begin
    if (a_mem_chipselect && !a_mem_write) a_mem_readdata <= pat(a_mem_address);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; preload = 1; idle();
    cyc();
    preload = 0;
    m0_read = 1; m1_read = 1;
    @(negedge clk);
    n_checks++; if (m0_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_m0_wait got %b want 1", m0_waitrequest); end
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_m1_wait got %b want 1", m1_waitrequest); end
    n_checks++; if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs got %b want 0", mem_chipselect); end
    n_checks++; if (mem_clken !== 1'b1) begin n_fail++; $display("FAIL rst_clken got %b want 1", mem_clken); end
    n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rdv got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
    n_checks++; if (m0_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_m0_rdata got %h want 0", m0_readdata); end
    n_checks++; if (m1_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_m1_rdata got %h want 0", m1_readdata); end
    cyc();
    idle();
    reset = 0;
  endtask

  task automatic test_write_read();
    do_reset();
    m0_write = 1; m0_address = 14'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    @(negedge clk);
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL wr_m0_wait got %b want 0", m0_waitrequest); end
    n_checks++; if ({mem_chipselect, mem_write} !== 2'b11) begin n_fail++; $display("FAIL wr_mem_cs_we got %b want 11", {mem_chipselect, mem_write}); end
    cyc();
    m0_write = 0; m0_read = 1;
    @(negedge clk);
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rd_m0_wait got %b want 0", m0_waitrequest); end
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rd_mem_we got %b want 0", mem_write); end
    cyc();
    idle();
    @(negedge clk);
    n_checks++; if (m0_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL rd_m0_rdv got %b want 1", m0_readdatavalid); end
    n_checks++; if (m0_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_m0_data got %h want deadbeef", m0_readdata); end
    n_checks++; if (m1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rd_m1_rdv got %b want 0", m1_readdatavalid); end
    n_checks++; if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL idle_cs got %b want 0", mem_chipselect); end
    cyc();
  endtask

  // Continuous contention with MAX_HOLD=4: M0 x4, M1 x4, M0 x4
  task automatic test_hold4();
    int n0 = 0, n1 = 0;
    logic pv = 0, pg = 0, eg;
    logic [13:0] pa = '0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      m0_read = 1; m1_read = 1;
      m0_address = 14'h100 + 14'(n0); m1_address = 14'h200 + 14'(n1);
      eg = (c >= 4 && c < 8);
      @(negedge clk);
      n_checks++; if (m0_waitrequest !== eg) begin n_fail++; $display("FAIL h4_m0_wait c=%0d got %b want %b", c, m0_waitrequest, eg); end
      n_checks++; if (m1_waitrequest !== !eg) begin n_fail++; $display("FAIL h4_m1_wait c=%0d got %b want %b", c, m1_waitrequest, !eg); end
      n_checks++; if ({m1_readdatavalid, m0_readdatavalid} !== {pv & pg, pv & !pg}) begin n_fail++; $display("FAIL h4_rdv c=%0d got %b want %b", c, {m1_readdatavalid, m0_readdatavalid}, {pv & pg, pv & !pg}); end
      if (pv) begin
        n_checks++; if ((pg ? m1_readdata : m0_readdata) !== pat(pa)) begin n_fail++; $display("FAIL h4_data c=%0d got %h want %h", c, pg ? m1_readdata : m0_readdata, pat(pa)); end
      end
      pv = 1; pg = eg; pa = eg ? m1_address : m0_address;
      if (eg) n1++; else n0++;
      cyc();
    end
    idle();
    @(negedge clk);
    n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== pat(pa)) begin n_fail++; $display("FAIL h4_last got v=%b d=%h want v=1 d=%h", m0_readdatavalid, m0_readdata, pat(pa)); end
    cyc();
  endtask

  // MAX_HOLD=1: strict alternation starting with m0
  task automatic test_alternate();
    int n0 = 0, n1 = 0;
    logic pv = 0, pg = 0, eg;
    logic [13:0] pa = '0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      m0_read = 1; m1_read = 1;
      m0_address = 14'h100 + 14'(n0); m1_address = 14'h200 + 14'(n1);
      eg = c[0];
      @(negedge clk);
      n_checks++; if ({a_m1_waitrequest, a_m0_waitrequest} !== {!eg, eg}) begin n_fail++; $display("FAIL alt_wait c=%0d got %b want %b", c, {a_m1_waitrequest, a_m0_waitrequest}, {!eg, eg}); end
      if (pv) begin
        n_checks++; if ({a_m1_readdatavalid, a_m0_readdatavalid} !== {pg, !pg}) begin n_fail++; $display("FAIL alt_rdv c=%0d got %b want %b", c, {a_m1_readdatavalid, a_m0_readdatavalid}, {pg, !pg}); end
        n_checks++; if ((pg ? a_m1_readdata : a_m0_readdata) !== pat(pa)) begin n_fail++; $display("FAIL alt_data c=%0d got %h want %h", c, pg ? a_m1_readdata : a_m0_readdata, pat(pa)); end
      end
      pv = 1; pg = eg; pa = eg ? m1_address : m0_address;
      if (eg) n1++; else n0++;
      cyc();
    end
    idle();
    cyc();
  endtask

  task automatic test_byte_lane();
    idle();
    m1_write = 1; m1_address = 14'h3FFF; m1_writedata = 32'h11223344; m1_byteenable = 4'hF;
    @(negedge clk);
    n_checks++; if (m1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL bl_m1_wait got %b want 0", m1_waitrequest); end
    n_checks++; if (mem_address !== 14'h3FFF) begin n_fail++; $display("FAIL bl_addr got %h want 3fff", mem_address); end
    cyc();
    m1_writedata = 32'h000000AA; m1_byteenable = 4'b0001;
    @(negedge clk);
    n_checks++; if (mem_byteenable !== 4'b0001) begin n_fail++; $display("FAIL bl_be got %b want 0001", mem_byteenable); end
    cyc();
    m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
    cyc();
    idle();
    @(negedge clk);
    n_checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h112233AA) begin n_fail++; $display("FAIL bl_read got v=%b d=%h want v=1 d=112233aa", m1_readdatavalid, m1_readdata); end
    n_checks++; if (m0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL bl_m0_rdv got %b want 0", m0_readdatavalid); end
    cyc();
  endtask

  task automatic test_rw_collision();
    idle();
    m0_read = 1; m0_write = 1; m0_address = 14'h0020; m0_writedata = 32'h5555AAAA;
    @(negedge clk);
    n_checks++; if ({mem_chipselect, mem_write} !== 2'b11) begin n_fail++; $display("FAIL rw_cs_we got %b want 11", {mem_chipselect, mem_write}); end
    n_checks++; if (mem_writedata !== 32'h5555AAAA) begin n_fail++; $display("FAIL rw_wdata got %h want 5555aaaa", mem_writedata); end
    cyc();
    idle();
    @(negedge clk);
    n_checks++; if (m0_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rw_no_rdv got %b want 0", m0_readdatavalid); end
    cyc();
    m0_read = 1; m0_address = 14'h0020;
    cyc();
    idle();
    @(negedge clk);
    n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h5555AAAA) begin n_fail++; $display("FAIL rw_read got v=%b d=%h want v=1 d=5555aaaa", m0_readdatavalid, m0_readdata); end
    cyc();
  endtask

  task automatic test_reset_mid();
    idle();
    m1_read = 1; m1_address = 14'h0205;
    @(negedge clk);
    n_checks++; if (m1_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rm_m1_wait got %b want 0", m1_waitrequest); end
    cyc();
    idle();
    reset = 1;
    @(negedge clk);
    n_checks++; if (m1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rm_rdv_in_reset got %b want 0", m1_readdatavalid); end
    cyc();
    reset = 0;
    m0_read = 1; m1_read = 1; m0_address = 14'h0100; m1_address = 14'h0200;
    @(negedge clk);
    n_checks++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin n_fail++; $display("FAIL rm_rdv_after got %b want 00", {m1_readdatavalid, m0_readdatavalid}); end
    n_checks++; if ({m1_waitrequest, m0_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL rm_first_grant got %b want 10", {m1_waitrequest, m0_waitrequest}); end
    cyc();
    @(negedge clk);
    n_checks++; if ({m1_waitrequest, m0_waitrequest} !== 2'b10) begin n_fail++; $display("FAIL rm_hold_grant got %b want 10", {m1_waitrequest, m0_waitrequest}); end
    n_checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== pat(14'h0100)) begin n_fail++; $display("FAIL rm_m0_read got v=%b d=%h want v=1 d=%h", m0_readdatavalid, m0_readdata, pat(14'h0100)); end
    cyc();
    idle();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_hold4();
    test_alternate();
    test_byte_lane();
    test_rw_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_nios2_attempt_mem_arbiter.md
Name: sd_nios2_attempt_mem_arbiter

Overview:
Two-master Avalon-MM arbiter that shares the 16K x 32 single-port on-chip RAM between the Nios II data master (m0) and the SD block-transfer DMA master (m1). It issues at most one access per cycle to the RAM and tracks the RAM's fixed 1-cycle read latency, so each read's data returns to its issuer with readdatavalid. Fairness is weighted round-robin with a bounded hold count.

Parameters:
ADDR_W, 14, word address width (16384 words)
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
MAX_HOLD, 4, max consecutive grants to one master while the other waits; legal 1..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  BE_W  master 0 byte lanes
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid
m0_waitrequest  out  1  master 0 stall
m1_*  (same eight signals, same widths and directions)  master 1
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  BE_W  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken; constant 1
mem_readdata  in  DATA_W  from RAM, valid 1 cycle after address is presented

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Request: reqN = mN_read | mN_write. If read and write are asserted together, that is a protocol violation. The access is treated as a write and the read is dropped.
- Grant is combinational each cycle from the registered state (last_owner, hold_cnt):
  - Only one master requesting: grant it.
  - Both requesting, owner = last_owner: keep owner if hold_cnt < MAX_HOLD-1, else grant the other master.
  - Neither requesting: no grant. mem_chipselect=0 and mem_write=0.
- State update on every grant:
  - Same master as last_owner: hold_cnt++ (saturates at 15).
  - Otherwise: last_owner = grantee and hold_cnt = 0.
  - Idle cycles leave the state unchanged.
- Memory drive: mem_address, mem_byteenable and mem_writedata are muxed from the grantee; mem_chipselect=1 when granted; mem_write = grantee's write.
- Waitrequest: mN_waitrequest = reqN & ~grantN. An access completes in the cycle it is presented with waitrequest low. Zero-wait single-cycle issue, throughput 1 access/cycle.
- Read return, one-stage pipeline registers rd_pend and rd_id:
  - Set on a granted read.
  - Next cycle: mN_readdata = mem_readdata and mN_readdatavalid = rd_pend & (rd_id==N).
  - Readdata for the non-owner holds its last value.
  - Back-to-back reads from alternating masters each return exactly one cycle later.
- Read-during-write to the same address by the other master in the following cycle: the RAM gives DONT_CARE. The arbiter does not reorder and does not guarantee coherency.
- Reset values: last_owner=1 (so m0 wins the first contention), hold_cnt=0, rd_pend=0, both readdatavalid=0, readdata=0.
  - While reset=1: both waitrequest=1 and mem_chipselect=0.
- Reset mid-operation: a pending read is discarded and no readdatavalid is produced in the cycle after reset.
- MAX_HOLD=1 gives strict alternation under continuous contention.

Decomposition:
- Package sd_mem_arb_pkg:
  - ADDR_W/DATA_W/BE_W defaults
  - master_id_t enum {M_CPU=0, M_DMA=1}
  - HOLD_CNT_W=4
- One sub-module, sd_mem_arb_rr: pure grant/fairness logic (req[1:0], last_owner, hold_cnt → grant[1:0], next state).
- The top level holds the mux, the read-return pipeline and the waitrequest logic.

Test Plan:
- m0 writes 0xDEADBEEF to addr 0x0010 (be=4'hF), then reads 0x0010 → m0_waitrequest=0 both cycles; m0_readdatavalid=1 one cycle after the read, data 0xDEADBEEF; m1_readdatavalid stays 0.
- Both masters continuously read (m0 addr 0x100.., m1 addr 0x200..) with MAX_HOLD=4 → grant sequence M0 x4, M1 x4, M0 x4; every readdata matches its preloaded word, routed to the issuer.
- MAX_HOLD=1, both requesting → strict alternation M0, M1, M0, M1; the stalled master sees waitrequest=1 on alternate cycles.
- Byte-lane write: m1 writes 0x000000AA with be=4'b0001 over 0x11223344 at 0x3FFF (top address), then reads → 0x112233AA.
- m0 asserts read+write together at 0x0020 with data 0x5555AAAA → treated as a write, no readdatavalid; a later read returns 0x5555AAAA.
- Reset asserted in the cycle after a granted m1 read → no m1_readdatavalid. Post-reset, both masters request → m0 granted first, hold_cnt=0.
